conv_sched: RTL

//  Sequencer for the 9-input multiply + adder_tree datapath of one convolution lane.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_sched_fifo.sv | 66 ++++++
 rtl/conv_sched.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and defaults for the convolution lane sequencer
// Purpose: FSM state encoding, latency-pipe tag layout and default tree latency
//          used by conv_sched.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // One entry of the tree-latency shadow pipe: a real window is in the tree,
  // and whether it opens or closes a pixel's channel sequence.
  typedef struct packed {
    logic v;
    logic first;
    logic last;
  } lat_tag_t;

  localparam int TREE_LAT_DEFAULT = 4;

endpackage

// File: rtl/conv_sched_fifo.sv
// rtl/conv_sched_fifo.sv - synchronous output FIFO for finished pixel sums
// Purpose: WIDTH x DEPTH sync FIFO with occupancy count.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   push/push_data  write strobe and data
//   pop             read strobe (ignored when empty)
//   head_valid      FIFO non-empty
//   head_data       oldest entry (0 when empty)
//   count           current occupancy
module conv_sched_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       head_valid,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign head_valid = (count != '0);
  assign pop_ok     = pop && head_valid;
  // A push into a full FIFO is only legal when a pop frees the slot.
  assign push_ok    = push && ((count != CW'(DEPTH)) || pop_ok);
  // Gate the head so the outputs read 0 whenever nothing is queued.
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + CW'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_sched.sv
// rtl/conv_sched.sv - issue/accumulate sequencer for one convolution lane
// Purpose: accepts 3x3 windows, drives mul_valid into the adder tree, shadows
//          the tree latency, accumulates cfg_cin channels per pixel and queues
//          finished sums in a credit-gated output FIFO.
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   cfg_start/cin/npix    job start pulse and configuration (IDLE only)
//   win_valid/win_ready   line-buffer window handshake
//   mul_valid             real window on the tree input this cycle
//   tree_dout             adder tree result
//   out_valid/data/ready  finished pixel stream
//   busy, done            job active, last-pixel pop pulse
// Build option: CONV_SCHED_RELU_EN clamps negative pushed sums to 0.
module conv_sched
  import conv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int TREE_LAT  = TREE_LAT_DEFAULT,
  parameter int OUT_DEPTH = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [CNT_W-1:0] cfg_cin,
  input  logic [CNT_W-1:0] cfg_npix,
  input  logic             win_valid,
  output logic             win_ready,
  output logic             mul_valid,
  input  logic [WIDTH-1:0] tree_dout,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(OUT_DEPTH + 1);

  sched_state_t     state, state_n;
  logic [CNT_W-1:0] cin_r, npix_r, ch_cnt, pix_cnt;
  logic [WIDTH-1:0] acc, sum, push_data;
  lat_tag_t         pipe [TREE_LAT];
  lat_tag_t         ex;
  logic [CW:0]      inflight_last, credit_sum;
  logic [CW-1:0]    fifo_count;
  logic             pipe_empty, credit_ok, issue, tag_first, tag_last;
  logic             push, pop;

  assign tag_first = (ch_cnt == '0);
  assign tag_last  = (ch_cnt == cin_r - CNT_W'(1));

  always_comb begin
    inflight_last = '0;
    pipe_empty    = 1'b1;
    for (int i = 0; i < TREE_LAT; i++) begin
      if (pipe[i].v) pipe_empty = 1'b0;
      if (pipe[i].v && pipe[i].last) inflight_last = inflight_last + (CW+1)'(1);
    end
  end

  // Every pixel closing in the tree will need a FIFO slot; reserve them now.
  assign credit_sum = (CW+1)'(fifo_count) + inflight_last;
  assign credit_ok  = (credit_sum < (CW+1)'(OUT_DEPTH));

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) state_n = (cfg_npix == '0) ? DONE : RUN;
      end
      RUN: begin
        issue = win_valid && credit_ok;
        if (issue && tag_last && (pix_cnt == npix_r - CNT_W'(1))) state_n = DRAIN;
      end
      DRAIN: begin
        if (pipe_empty && (fifo_count == '0)) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign win_ready = issue;
  assign mul_valid = issue;
  assign busy      = (state != IDLE);

  assign ex  = pipe[TREE_LAT-1];
  assign sum = ex.first ? tree_dout : acc + tree_dout;
`ifdef CONV_SCHED_RELU_EN
  assign push_data = sum[WIDTH-1] ? '0 : sum;
`else
  assign push_data = sum;
`endif
  assign push = ex.v && ex.last;
  assign pop  = out_valid && out_ready;

  // With the pipe empty in DRAIN nothing more can be pushed, so a pop of the
  // single remaining entry is the job's final pop. A zero-pixel job signals
  // completion from DONE instead.
  assign done = ((state == DRAIN) && pipe_empty && (fifo_count == CW'(1)) && pop)
             || ((state == DONE) && (npix_r == '0));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cin_r   <= '0;
      npix_r  <= '0;
      ch_cnt  <= '0;
      pix_cnt <= '0;
      acc     <= '0;
      for (int i = 0; i < TREE_LAT; i++) pipe[i] <= '0;
    end else begin
      state <= state_n;
      if ((state == IDLE) && cfg_start) begin
        cin_r   <= (cfg_cin == '0) ? CNT_W'(1) : cfg_cin;
        npix_r  <= cfg_npix;
        ch_cnt  <= '0;
        pix_cnt <= '0;
      end else if (issue) begin
        if (tag_last) begin
          ch_cnt  <= '0;
          pix_cnt <= pix_cnt + CNT_W'(1);
        end else begin
          ch_cnt <= ch_cnt + CNT_W'(1);
        end
      end
      pipe[0].v     <= issue;
      pipe[0].first <= issue && tag_first;
      pipe[0].last  <= issue && tag_last;
      for (int i = 1; i < TREE_LAT; i++) pipe[i] <= pipe[i-1];
      if (ex.v) acc <= sum;
    end
  end

  conv_sched_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head_valid (out_valid),
    .head_data  (out_data),
    .count      (fifo_count)
  );

endmodule
